switch_host_port: RTL and testbench

SWITCH_HOST_PORT -- requirements
Module: switch_host_port

---
 rtl/switch_host_port_if.sv | 40 ++++
 rtl/switch_host_port.sv | 184 ++++++++++++++++++
 tb/tb_switch_host_port.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/switch_host_port_if.sv
// Bus bundle between a switch host node and its environment: the host-side
// TX handshake, the packet lines into/out of the switch port, and the host-side
// RX report. "master" is the environment (host + switch), "slave" is the node.
interface switch_host_port_if;
  // Host TX handshake
  logic       tx_valid;
  logic       tx_ready;
  logic [3:0] tx_target;
  logic [7:0] tx_data;
  // Node -> switch port
  logic       pkt_valid_o;
  logic [3:0] pkt_source_o;
  logic [3:0] pkt_target_o;
  logic [7:0] pkt_data_o;
  // Switch port -> node
  logic       pkt_valid_i;
  logic [3:0] pkt_source_i;
  logic [3:0] pkt_target_i;
  logic [7:0] pkt_data_i;
  // Node -> host RX report
  logic       rx_valid;
  logic [3:0] rx_source;
  logic [7:0] rx_data;

  modport master (
    output tx_valid, tx_target, tx_data,
    input  tx_ready,
    input  pkt_valid_o, pkt_source_o, pkt_target_o, pkt_data_o,
    output pkt_valid_i, pkt_source_i, pkt_target_i, pkt_data_i,
    input  rx_valid, rx_source, rx_data
  );

  modport slave (
    input  tx_valid, tx_target, tx_data,
    output tx_ready,
    output pkt_valid_o, pkt_source_o, pkt_target_o, pkt_data_o,
    input  pkt_valid_i, pkt_source_i, pkt_target_i, pkt_data_i,
    output rx_valid, rx_source, rx_data
  );
endinterface

// File: rtl/switch_host_port.sv
// Host-side node for one switch port. Queues host packets in a small FIFO and
// sends them as one-cycle pulses with a configurable idle gap; reports packets
// coming back from the switch as one-cycle rx pulses.
// Optional build macro SWITCH_HOST_PORT_RX_CHECK_EN: flag received packets whose
// target mask does not include this port on rx_err.
module switch_host_port #(
  parameter int PORT_ID    = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  switch_host_port_if.slave bus,
  output logic [7:0]        tx_drop_cnt,
  output logic              rx_err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [1:0]    PID      = PORT_ID[1:0];
  localparam logic [3:0]    SRC_CODE = 4'b0001 << PID;
  localparam logic [3:0]    GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  typedef struct packed {
    logic [3:0] target;
    logic [7:0] data;
  } entry_t;

  entry_t          mem [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr, rd_ptr_inc;
  logic [CW-1:0]   count;
  logic            ready_q;
  logic            accept, push, drop, pop, more_after_pop;
  state_t          state, state_next;
  logic            load_out;
  entry_t          head_sel;
  logic [3:0]      gap_cnt;

  assign bus.tx_ready   = ready_q && (count < DEPTH_C);
  assign accept         = bus.tx_valid && bus.tx_ready;
  assign push           = accept && (bus.tx_target != 4'b0000);
  assign drop           = accept && (bus.tx_target == 4'b0000);
  assign pop            = (state == SEND);
  assign rd_ptr_inc     = rd_ptr + 1'b1;
  // A push landing on the same edge as the pop keeps a lone entry's successor alive.
  assign more_after_pop = (count > CW'(1)) || push;

  // Hold tx_ready low during reset and raise it on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  // FIFO storage write port.
  // NOTE: the storage array is not reset; pointers and count alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{target: bus.tx_target, data: bus.tx_data};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: all sequential state uses non-blocking assignment so every register samples pre-edge values.
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr_inc;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode and choice of the entry to present on the next pulse.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next = state;
    load_out   = 1'b0;
    head_sel   = mem[rd_ptr];
    case (state)
      IDLE: begin
        if (count != '0) begin
          state_next = SEND;
          load_out   = 1'b1;
        end
      end
      SEND: begin
        if (GAP_CYCLES > 0) begin
          state_next = GAP;
        end else if (more_after_pop) begin
          state_next = SEND;
          load_out   = 1'b1;
          head_sel   = (count > CW'(1)) ? mem[rd_ptr_inc]
                                        : '{target: bus.tx_target, data: bus.tx_data};
        end else begin
          state_next = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == 4'd0) begin
          if (count != '0) begin
            state_next = SEND;
            load_out   = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Inter-packet gap counter: loaded on leaving SEND, counts down while in GAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  gap_cnt <= 4'd0;
    else if (state == SEND && state_next == GAP) gap_cnt <= GAP_LOAD;
    else if (state == GAP && gap_cnt != 4'd0)    gap_cnt <= gap_cnt - 4'd1;
  end

  // Packet output registers: populated only for the single SEND cycle, zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.pkt_valid_o  <= 1'b0;
      bus.pkt_source_o <= 4'b0000;
      bus.pkt_target_o <= 4'b0000;
      bus.pkt_data_o   <= 8'h00;
    end else if (load_out) begin
      bus.pkt_valid_o  <= 1'b1;
      bus.pkt_source_o <= SRC_CODE;
      bus.pkt_target_o <= head_sel.target;
      bus.pkt_data_o   <= head_sel.data;
    end else begin
      bus.pkt_valid_o  <= 1'b0;
      bus.pkt_source_o <= 4'b0000;
      bus.pkt_target_o <= 4'b0000;
      bus.pkt_data_o   <= 8'h00;
    end
  end

  // Saturating count of accepted requests that carried an empty target mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           tx_drop_cnt <= 8'h00;
    else if (drop && tx_drop_cnt != 8'hFF) tx_drop_cnt <= tx_drop_cnt + 8'h01;
  end

  // Receive report: one-cycle pulse, payload fields hold until the next packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rx_valid  <= 1'b0;
      bus.rx_source <= 4'b0000;
      bus.rx_data   <= 8'h00;
    end else begin
      bus.rx_valid <= bus.pkt_valid_i;
      if (bus.pkt_valid_i) begin
        bus.rx_source <= bus.pkt_source_i;
        bus.rx_data   <= bus.pkt_data_i;
      end
    end
  end

`ifdef SWITCH_HOST_PORT_RX_CHECK_EN
  // Flag a received packet whose target mask excludes this port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_err <= 1'b0;
    else        rx_err <= bus.pkt_valid_i && !bus.pkt_target_i[PID];
  end
`else
  assign rx_err = 1'b0;
`endif

endmodule

// File: tb/tb_switch_host_port.sv
// Directed bench for switch_host_port. Three nodes with different PORT_ID /
// GAP_CYCLES settings share clock and reset; a cycle table drives node A and
// hand-written sequences cover FIFO full, back-to-back, drop saturation, RX
// checking and reset during SEND.
module tb_switch_host_port;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

`ifdef SWITCH_HOST_PORT_RX_CHECK_EN
  localparam logic RX_CHK = 1'b1;
`else
  localparam logic RX_CHK = 1'b0;
`endif

  switch_host_port_if a_if ();
  switch_host_port_if b_if ();
  switch_host_port_if c_if ();
  logic [7:0] a_drop, b_drop, c_drop;
  logic       a_err, b_err, c_err;

  switch_host_port #(.PORT_ID(2), .FIFO_DEPTH(4), .GAP_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if.slave), .tx_drop_cnt(a_drop), .rx_err(a_err));
  switch_host_port #(.PORT_ID(1), .FIFO_DEPTH(4), .GAP_CYCLES(15)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if.slave), .tx_drop_cnt(b_drop), .rx_err(b_err));
  switch_host_port #(.PORT_ID(0), .FIFO_DEPTH(4), .GAP_CYCLES(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(c_if.slave), .tx_drop_cnt(c_drop), .rx_err(c_err));

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse monitors, sampled on the falling edge.
  typedef struct {
    int         cyc;
    logic [3:0] src;
    logic [3:0] tgt;
    logic [7:0] data;
  } pulse_t;

  int     cyc = 0;
  int     a_pulses = 0;
  pulse_t b_q[$];
  pulse_t c_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_if.pkt_valid_o) a_pulses++;
    if (b_if.pkt_valid_o) b_q.push_back('{cyc, b_if.pkt_source_o, b_if.pkt_target_o, b_if.pkt_data_o});
    if (c_if.pkt_valid_o) c_q.push_back('{cyc, c_if.pkt_source_o, c_if.pkt_target_o, c_if.pkt_data_o});
  end

  // Node A observable state: {ready, pkt valid/src/tgt/data, rx valid/src/data, err, drop}
  function automatic logic [39:0] pack_a();
    return {a_if.tx_ready, a_if.pkt_valid_o, a_if.pkt_source_o, a_if.pkt_target_o,
            a_if.pkt_data_o, a_if.rx_valid, a_if.rx_source, a_if.rx_data, a_err, a_drop};
  endfunction

  function automatic logic [39:0] mk_exp(input logic rdy, input logic pv, input logic [3:0] src,
                                         input logic [3:0] tgt, input logic [7:0] d,
                                         input logic rxv, input logic [3:0] rxs,
                                         input logic [7:0] rxd, input logic err,
                                         input logic [7:0] drp);
    return {rdy, pv, src, tgt, d, rxv, rxs, rxd, err, drp};
  endfunction

  task automatic drive(input int sel, input logic v, input logic [3:0] tgt, input logic [7:0] d);
    case (sel)
      0: begin a_if.tx_valid = v; a_if.tx_target = tgt; a_if.tx_data = d; end
      1: begin b_if.tx_valid = v; b_if.tx_target = tgt; b_if.tx_data = d; end
      default: begin c_if.tx_valid = v; c_if.tx_target = tgt; c_if.tx_data = d; end
    endcase
  endtask

  function automatic logic ready_of(input int sel);
    case (sel)
      0:       return a_if.tx_ready;
      1:       return b_if.tx_ready;
      default: return c_if.tx_ready;
    endcase
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance with tx_valid still high.
  task automatic push(input int sel, input logic [3:0] tgt, input logic [7:0] d);
    logic done;
    done = 1'b0;
    drive(sel, 1'b1, tgt, d);
    for (int i = 0; i < 64 && !done; i++) begin
      if (ready_of(sel)) begin
        @(posedge clk);
        done = 1'b1;
      end
      @(negedge clk);
    end
    if (!done) check($sformatf("push_timeout_%0d", sel), {63'd0, done}, 64'd1);
  endtask

  typedef struct {
    logic        tx_valid;
    logic [3:0]  tx_target;
    logic [7:0]  tx_data;
    logic        pv_i;
    logic [3:0]  src_i;
    logic [3:0]  tgt_i;
    logic [7:0]  data_i;
    logic [39:0] exp;
  } vec_t;

  vec_t tv[11];

  initial begin
    int base;
    logic got;

    tv[0]  = '{1'b1, 4'b0001, 8'hA5, 1'b0, 4'h0, 4'h0, 8'h00,
               mk_exp(1, 0, 4'h0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 0, 8'd0)};
    tv[1]  = '{1'b0, 4'b0000, 8'h00, 1'b0, 4'h0, 4'h0, 8'h00,
               mk_exp(1, 1, 4'b0100, 4'b0001, 8'hA5, 0, 4'h0, 8'h00, 0, 8'd0)};
    tv[2]  = '{1'b0, 4'b0000, 8'h00, 1'b0, 4'h0, 4'h0, 8'h00,
               mk_exp(1, 0, 4'h0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 0, 8'd0)};
    tv[3]  = '{1'b1, 4'b1000, 8'h11, 1'b1, 4'b0001, 4'b0100, 8'h3C,
               mk_exp(1, 0, 4'h0, 4'h0, 8'h00, 1, 4'b0001, 8'h3C, 0, 8'd0)};
    tv[4]  = '{1'b0, 4'b0000, 8'h00, 1'b1, 4'b1000, 4'b0001, 8'hC3,
               mk_exp(1, 1, 4'b0100, 4'b1000, 8'h11, 1, 4'b1000, 8'hC3, RX_CHK, 8'd0)};
    tv[5]  = '{1'b1, 4'b0010, 8'h22, 1'b0, 4'h0, 4'h0, 8'h00,
               mk_exp(1, 0, 4'h0, 4'h0, 8'h00, 0, 4'b1000, 8'hC3, 0, 8'd0)};
    tv[6]  = '{1'b1, 4'b0110, 8'h33, 1'b0, 4'h0, 4'h0, 8'h00,
               mk_exp(1, 1, 4'b0100, 4'b0010, 8'h22, 0, 4'b1000, 8'hC3, 0, 8'd0)};
    tv[7]  = '{1'b0, 4'b0000, 8'h00, 1'b0, 4'h0, 4'h0, 8'h00,
               mk_exp(1, 0, 4'h0, 4'h0, 8'h00, 0, 4'b1000, 8'hC3, 0, 8'd0)};
    tv[8]  = '{1'b0, 4'b0000, 8'h00, 1'b0, 4'h0, 4'h0, 8'h00,
               mk_exp(1, 1, 4'b0100, 4'b0110, 8'h33, 0, 4'b1000, 8'hC3, 0, 8'd0)};
    tv[9]  = '{1'b1, 4'b0000, 8'hFF, 1'b0, 4'h0, 4'h0, 8'h00,
               mk_exp(1, 0, 4'h0, 4'h0, 8'h00, 0, 4'b1000, 8'hC3, 0, 8'd1)};
    tv[10] = '{1'b0, 4'b0000, 8'h00, 1'b0, 4'h0, 4'h0, 8'h00,
               mk_exp(1, 0, 4'h0, 4'h0, 8'h00, 0, 4'b1000, 8'hC3, 0, 8'd1)};

    // Quiet all inputs and hold reset.
    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 4'h0, 8'h00);
    a_if.pkt_valid_i = 0; a_if.pkt_source_i = 0; a_if.pkt_target_i = 0; a_if.pkt_data_i = 0;
    b_if.pkt_valid_i = 0; b_if.pkt_source_i = 0; b_if.pkt_target_i = 0; b_if.pkt_data_i = 0;
    c_if.pkt_valid_i = 0; c_if.pkt_source_i = 0; c_if.pkt_target_i = 0; c_if.pkt_data_i = 0;
    repeat (3) @(negedge clk);
    check("reset_state_a", pack_a(), 40'd0);
    check("reset_ready_b", b_if.tx_ready, 1'b0);

    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", a_if.tx_ready, 1'b1);

    // Cycle table on node A (PORT_ID=2, GAP_CYCLES=1).
    for (int i = 0; i < 11; i++) begin
      a_if.tx_valid     = tv[i].tx_valid;
      a_if.tx_target    = tv[i].tx_target;
      a_if.tx_data      = tv[i].tx_data;
      a_if.pkt_valid_i  = tv[i].pv_i;
      a_if.pkt_source_i = tv[i].src_i;
      a_if.pkt_target_i = tv[i].tgt_i;
      a_if.pkt_data_i   = tv[i].data_i;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), pack_a(), tv[i].exp);
    end
    a_if.pkt_valid_i = 1'b0;
    drive(0, 1'b0, 4'h0, 8'h00);
    @(negedge clk);

    // 300 zero-target accepts: nothing sent, drop counter saturates.
    base = a_pulses;
    drive(0, 1'b1, 4'b0000, 8'hEE);
    repeat (300) @(negedge clk);
    drive(0, 1'b0, 4'h0, 8'h00);
    repeat (3) @(negedge clk);
    check("drop_sat_cnt", a_drop, 8'd255);
    check("drop_no_pulse", a_pulses - base, 0);

    // RX on node B (PORT_ID=1): misrouted then correctly routed packet.
    b_if.pkt_valid_i = 1'b1; b_if.pkt_source_i = 4'b0001;
    b_if.pkt_target_i = 4'b0100; b_if.pkt_data_i = 8'h3C;
    @(posedge clk); #1;
    check("rx_bad_pulse", {b_if.rx_valid, b_err, b_if.rx_source, b_if.rx_data},
          {1'b1, RX_CHK, 4'b0001, 8'h3C});
    b_if.pkt_source_i = 4'b1000; b_if.pkt_target_i = 4'b0010; b_if.pkt_data_i = 8'h5D;
    @(posedge clk); #1;
    check("rx_good_pulse", {b_if.rx_valid, b_err, b_if.rx_source, b_if.rx_data},
          {1'b1, 1'b0, 4'b1000, 8'h5D});
    b_if.pkt_valid_i = 1'b0; b_if.pkt_data_i = 8'h00;
    @(posedge clk); #1;
    check("rx_hold", {b_if.rx_valid, b_err, b_if.rx_source, b_if.rx_data},
          {1'b1 ^ 1'b1, 1'b0, 4'b1000, 8'h5D});
    @(negedge clk);

    // Node B (GAP_CYCLES=15): five back-to-back pushes fill the FIFO.
    base = b_q.size();
    for (int k = 1; k <= 5; k++) push(1, 4'b0001, 8'(k));
    check("b_full_ready", b_if.tx_ready, 1'b0);
    drive(1, 1'b0, 4'h0, 8'h00);
    repeat (100) @(negedge clk);
    check("b_pulse_count", b_q.size() - base, 5);
    for (int k = 0; k < 5 && base + k < b_q.size(); k++) begin
      check($sformatf("b_pkt%0d", k),
            {b_q[base+k].src, b_q[base+k].tgt, b_q[base+k].data},
            {4'b0010, 4'b0001, 8'(k + 1)});
      if (k > 0)
        check($sformatf("b_gap%0d", k), b_q[base+k].cyc - b_q[base+k-1].cyc - 1, 15);
    end
    check("b_ready_after_drain", b_if.tx_ready, 1'b1);

    // Node C (GAP_CYCLES=0): three queued packets go out on consecutive cycles.
    base = c_q.size();
    push(2, 4'b0011, 8'h71);
    push(2, 4'b0101, 8'h72);
    push(2, 4'b1001, 8'h73);
    drive(2, 1'b0, 4'h0, 8'h00);
    repeat (10) @(negedge clk);
    check("c_pulse_count", c_q.size() - base, 3);
    if (c_q.size() - base == 3) begin
      check("c_pkt0", {c_q[base].src, c_q[base].tgt, c_q[base].data}, {4'b0001, 4'b0011, 8'h71});
      check("c_pkt1", {c_q[base+1].src, c_q[base+1].tgt, c_q[base+1].data}, {4'b0001, 4'b0101, 8'h72});
      check("c_pkt2", {c_q[base+2].src, c_q[base+2].tgt, c_q[base+2].data}, {4'b0001, 4'b1001, 8'h73});
      check("c_b2b_span", c_q[base+2].cyc - c_q[base].cyc, 2);
    end

    // Node C: a push on the same edge the only queued packet is sent follows it directly.
    base = c_q.size();
    push(2, 4'b0010, 8'h81);
    drive(2, 1'b0, 4'h0, 8'h00);
    @(negedge clk);
    push(2, 4'b0100, 8'h82);
    drive(2, 1'b0, 4'h0, 8'h00);
    repeat (10) @(negedge clk);
    check("c_bypass_count", c_q.size() - base, 2);
    if (c_q.size() - base == 2) begin
      check("c_bypass_data", {c_q[base].data, c_q[base+1].data, c_q[base+1].tgt},
            {8'h81, 8'h82, 4'b0100});
      check("c_bypass_adjacent", c_q[base+1].cyc - c_q[base].cyc, 1);
    end

    // Node B: reset asserted while a packet is being sent with three queued.
    push(1, 4'b0001, 8'hA1);
    push(1, 4'b0001, 8'hA2);
    push(1, 4'b0001, 8'hA3);
    push(1, 4'b0001, 8'hA4);
    drive(1, 1'b0, 4'h0, 8'h00);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (b_if.pkt_valid_o) got = 1'b1;
      else @(negedge clk);
    end
    check("rst_reach_send", {63'd0, got}, 64'd1);
    check("rst_send_data", b_if.pkt_data_o, 8'hA2);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_clear", {b_if.pkt_valid_o, b_if.pkt_data_o, b_if.tx_ready}, 10'd0);
    @(negedge clk);
    rst_n = 1'b1;
    base = b_q.size();
    repeat (60) @(negedge clk);
    check("rst_no_stale_pulse", b_q.size() - base, 0);
    push(1, 4'b1000, 8'h5A);
    drive(1, 1'b0, 4'h0, 8'h00);
    repeat (5) @(negedge clk);
    check("rst_new_pulse_count", b_q.size() - base, 1);
    if (b_q.size() - base == 1)
      check("rst_new_pulse_data", {b_q[base].tgt, b_q[base].data}, {4'b1000, 8'h5A});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
